// File: rtl/ahb_seg_display_n_if.sv
// rtl/ahb_seg_display_n_if.sv - AHB-Lite slave bus bundle for the seven-segment display
// Carries the address/data-phase signals between bus fabric and the display slave.
interface ahb_seg_display_n_if;
  logic        HSEL;
  logic        HREADY;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADYOUT;

  modport master (
    output HSEL, HREADY, HADDR, HTRANS, HWRITE, HWDATA,
    input  HRDATA, HREADYOUT
  );

  modport slave (
    input  HSEL, HREADY, HADDR, HTRANS, HWRITE, HWDATA,
    output HRDATA, HREADYOUT
  );
endinterface

// File: rtl/ahb_seg_display_n.sv
// rtl/ahb_seg_display_n.sv - AHB-Lite multiplexed N-digit seven-segment display driver
// Optional blink support is compiled in with SEGDISP_BLINK_EN.
module ahb_seg_display_n #(
  parameter int NDIG       = 8,
  parameter int SCAN_LOG2  = 13,
  parameter int BLINK_LOG2 = 24
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  ahb_seg_display_n_if.slave bus,
  output logic [7:0]        Seg_display,
  output logic [NDIG-1:0]   digit
);

  logic [2:0]            a_idx;
  logic                  a_wr;
  logic                  wr_en;

  logic [NDIG*4-1:0]     data_q;
  logic [NDIG-1:0]       dp_q;
  logic [NDIG-1:0]       blank_q;
  logic [3:0]            bright_q;
  logic                  enable_q;
  logic                  blink_q;
  logic                  blink_phase;

  logic [63:0]           data_all;
  logic [15:0]           dp_all;
  logic [15:0]           blank_all;

  logic [SCAN_LOG2-1:0]  slot_q;
  logic [3:0]            idx_q;

  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_blank;
  logic                  lit;
  logic [31:0]           rdata;

  logic                  unused_bits;

  // Address phase is captured only when the previous transfer completes.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      a_idx <= 3'd0;
      a_wr  <= 1'b0;
    end else if (bus.HREADY) begin
      a_idx <= bus.HADDR[4:2];
      a_wr  <= bus.HSEL & bus.HWRITE & bus.HTRANS[1];
    end
  end

  assign wr_en = a_wr & bus.HREADY;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      data_q   <= '0;
      dp_q     <= '0;
      blank_q  <= '0;
      bright_q <= 4'hF;
      enable_q <= 1'b1;
`ifdef SEGDISP_BLINK_EN
      blink_q  <= 1'b0;
`endif
    end else if (wr_en) begin
      case (a_idx)
        3'd0, 3'd1: begin
          // Word 0 holds digits 0..7, word 1 digits 8..15.
          for (int i = 0; i < NDIG; i++) begin
            if ((i < 8) == (a_idx == 3'd0))
              data_q[i*4 +: 4] <= bus.HWDATA[(i % 8)*4 +: 4];
          end
        end
        3'd2: dp_q    <= bus.HWDATA[NDIG-1:0];
        3'd3: blank_q <= bus.HWDATA[NDIG-1:0];
        3'd4: begin
          bright_q <= bus.HWDATA[3:0];
          enable_q <= bus.HWDATA[4];
`ifdef SEGDISP_BLINK_EN
          blink_q  <= bus.HWDATA[8];
`endif
        end
        default: ;
      endcase
    end
  end

`ifdef SEGDISP_BLINK_EN
  logic [BLINK_LOG2-1:0] blink_cnt_q;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      blink_cnt_q <= '0;
      blink_phase <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_q + BLINK_LOG2'(1);
      if (&blink_cnt_q)
        blink_phase <= ~blink_phase;
    end
  end
`else
  logic unused_blink_cfg;
  assign unused_blink_cfg = (BLINK_LOG2 > 0);
  assign blink_q          = 1'b0;
  assign blink_phase      = 1'b0;
`endif

  assign data_all  = 64'(data_q);
  assign dp_all    = 16'(dp_q);
  assign blank_all = 16'(blank_q);

  always_comb begin
    rdata = 32'h0;
    case (a_idx)
      3'd0:    rdata = data_all[31:0];
      3'd1:    rdata = data_all[63:32];
      3'd2:    rdata = {16'h0, dp_all};
      3'd3:    rdata = {16'h0, blank_all};
      3'd4:    rdata = {23'h0, blink_q, 3'h0, enable_q, bright_q};
      3'd5:    rdata = {23'h0, blink_phase, 4'h0, idx_q};
      default: rdata = 32'h0;
    endcase
  end

  assign bus.HRDATA    = rdata;
  assign bus.HREADYOUT = 1'b1;

  // Index wraps at NDIG-1 so non power-of-two digit counts have no idle slots.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      slot_q <= '0;
      idx_q  <= 4'd0;
    end else begin
      slot_q <= slot_q + SCAN_LOG2'(1);
      if (&slot_q)
        idx_q <= (idx_q == 4'(NDIG-1)) ? 4'd0 : idx_q + 4'd1;
    end
  end

  assign cur_nib   = data_all[{idx_q, 2'b00} +: 4];
  assign cur_dp    = dp_all[idx_q];
  assign cur_blank = blank_all[idx_q];

  // The top four slot bits split the slot into sixteenths for brightness PWM.
  assign lit = enable_q & ~cur_blank &
               (slot_q[SCAN_LOG2-1 -: 4] <= bright_q) &
               ~(blink_q & blink_phase);

  function automatic logic [6:0] hex_font(input logic [3:0] n);
    logic [6:0] f;
    case (n)
      4'h0: f = 7'h40;
      4'h1: f = 7'h79;
      4'h2: f = 7'h24;
      4'h3: f = 7'h30;
      4'h4: f = 7'h19;
      4'h5: f = 7'h12;
      4'h6: f = 7'h02;
      4'h7: f = 7'h78;
      4'h8: f = 7'h00;
      4'h9: f = 7'h10;
      4'hA: f = 7'h08;
      4'hB: f = 7'h03;
      4'hC: f = 7'h46;
      4'hD: f = 7'h21;
      4'hE: f = 7'h06;
      default: f = 7'h0E;
    endcase
    return f;
  endfunction

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      digit       <= '1;
      Seg_display <= 8'hFF;
    end else if (lit) begin
      digit       <= ~(NDIG'(1) << idx_q);
      Seg_display <= {hex_font(cur_nib), ~cur_dp};
    end else begin
      digit       <= '1;
      Seg_display <= 8'hFF;
    end
  end

  assign unused_bits = ^{bus.HADDR[31:5], bus.HADDR[1:0], bus.HTRANS[0]};

endmodule

// File: tb/tb_ahb_seg_display_n.sv
// tb/tb_ahb_seg_display_n.sv - self-checking bench for ahb_seg_display_n
// Two instances (8 digits fast scan, 5 digits slower scan) share one bus stimulus.
module tb_ahb_seg_display_n;
  localparam int ND0 = 8;
  localparam int S0  = 4;
  localparam int ND1 = 5;
  localparam int S1  = 6;
  localparam int BL  = 6;
`ifdef SEGDISP_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;

  logic        hsel = 1'b0, hready = 1'b1, hwrite = 1'b0;
  logic [31:0] haddr = 32'h0, hwdata = 32'h0;
  logic [1:0]  htrans = 2'b00;

  ahb_seg_display_n_if bus0();
  ahb_seg_display_n_if bus1();
  assign bus0.HSEL = hsel;   assign bus1.HSEL = hsel;
  assign bus0.HREADY = hready; assign bus1.HREADY = hready;
  assign bus0.HADDR = haddr; assign bus1.HADDR = haddr;
  assign bus0.HTRANS = htrans; assign bus1.HTRANS = htrans;
  assign bus0.HWRITE = hwrite; assign bus1.HWRITE = hwrite;
  assign bus0.HWDATA = hwdata; assign bus1.HWDATA = hwdata;

  logic [7:0]     seg0, seg1;
  logic [ND0-1:0] dig0;
  logic [ND1-1:0] dig1;

  ahb_seg_display_n #(.NDIG(ND0), .SCAN_LOG2(S0), .BLINK_LOG2(BL)) dut0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus0), .Seg_display(seg0), .digit(dig0));
  ahb_seg_display_n #(.NDIG(ND1), .SCAN_LOG2(S1), .BLINK_LOG2(BL)) dut1 (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus1), .Seg_display(seg1), .digit(dig1));

  // Reference model: register contents plus elapsed cycles since reset.
  logic [6:0]  font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [63:0] m_data [2];
  logic [15:0] m_dp [2], m_blank [2];
  logic [3:0]  m_bright [2];
  logic        m_en [2], m_blink [2];
  longint      cnt;
  logic [15:0] e_dig [2];
  logic [7:0]  e_seg [2];
  logic        pend_v = 1'b0;
  logic [2:0]  pend_a = 3'd0;
  logic [31:0] pend_d = 32'h0;

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b1;

  function automatic int nd_of(int d);  return (d == 0) ? ND0 : ND1; endfunction
  function automatic int s_of(int d);   return (d == 0) ? S0 : S1;   endfunction
  function automatic logic [15:0] nmask(int d);
    return 16'((32'd1 << nd_of(d)) - 32'd1);
  endfunction
  function automatic logic [63:0] dmask(int d);
    return (64'd1 << (4 * nd_of(d))) - 64'd1;
  endfunction

  function automatic logic [23:0] model_out(int d, longint c);
    longint slot  = c % (longint'(1) << s_of(d));
    int     idx   = int'((c >> s_of(d)) % nd_of(d));
    int     level = int'(slot >> (s_of(d) - 4));
    bit     bdark = BLINK_ON && m_blink[d] && (((c >> BL) % 2) == 1);
    if (m_en[d] && !m_blank[d][idx] && level <= int'(m_bright[d]) && !bdark)
      return {nmask(d) & ~(16'd1 << idx), font[m_data[d][idx*4 +: 4]], ~m_dp[d][idx]};
    return {nmask(d), 8'hFF};
  endfunction

  function automatic logic [31:0] model_rd(int d, logic [2:0] a);
    int idx = int'((cnt >> s_of(d)) % nd_of(d));
    int ph  = BLINK_ON ? int'((cnt >> BL) % 2) : 0;
    case (a)
      3'd0: return m_data[d][31:0];
      3'd1: return m_data[d][63:32];
      3'd2: return {16'h0, m_dp[d]};
      3'd3: return {16'h0, m_blank[d]};
      3'd4: return {23'h0, m_blink[d], 3'h0, m_en[d], m_bright[d]};
      3'd5: return 32'(idx) | (32'(ph) << 8);
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge HCLK) begin
    if (!HRESETn) begin
      cnt <= 0;
      for (int d = 0; d < 2; d++) begin
        m_data[d] <= 64'h0; m_dp[d] <= 16'h0; m_blank[d] <= 16'h0;
        m_bright[d] <= 4'hF; m_en[d] <= 1'b1; m_blink[d] <= 1'b0;
        e_dig[d] <= nmask(d); e_seg[d] <= 8'hFF;
      end
    end else begin
      cnt <= cnt + 1;
      for (int d = 0; d < 2; d++) begin
        {e_dig[d], e_seg[d]} <= model_out(d, cnt);
        if (pend_v) begin
          case (pend_a)
            3'd0: m_data[d]  <= {m_data[d][63:32], pend_d} & dmask(d);
            3'd1: m_data[d]  <= {pend_d, m_data[d][31:0]} & dmask(d);
            3'd2: m_dp[d]    <= pend_d[15:0] & nmask(d);
            3'd3: m_blank[d] <= pend_d[15:0] & nmask(d);
            3'd4: begin
              m_bright[d] <= pend_d[3:0];
              m_en[d]     <= pend_d[4];
              m_blink[d]  <= BLINK_ON & pend_d[8];
            end
            default: ;
          endcase
        end
      end
    end
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge HCLK);
    if (mon_en) begin
      check32("digit0", 32'(dig0), 32'(e_dig[0]));
      check32("seg0",   32'(seg0), 32'(e_seg[0]));
      check32("digit1", 32'(dig1), 32'(e_dig[1]));
      check32("seg1",   32'(seg1), 32'(e_seg[1]));
      check32("hreadyout", {30'h0, bus0.HREADYOUT, bus1.HREADYOUT}, 32'h3);
    end
  endtask

  task automatic xfer(input logic sel, input logic [1:0] tr, input logic wr,
                      input logic [31:0] addr, input logic [31:0] wd,
                      output logic [31:0] r0, output logic [31:0] r1);
    step();
    hsel = sel; htrans = tr; hwrite = wr; haddr = addr;
    step();
    r0 = bus0.HRDATA; r1 = bus1.HRDATA;
    check32("hrdata0", r0, model_rd(0, addr[4:2]));
    check32("hrdata1", r1, model_rd(1, addr[4:2]));
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; haddr = $urandom; hwdata = wd;
    pend_v = sel & tr[1] & wr; pend_a = addr[4:2]; pend_d = wd;
    step();
    pend_v = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    logic [31:0] r0, r1;
    xfer(1'b1, 2'b10, 1'b1, {27'h0, a, 2'b00}, d, r0, r1);
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] r0, output logic [31:0] r1);
    xfer(1'b1, 2'b10, 1'b0, {27'h0, a, 2'b00}, 32'h0, r0, r1);
  endtask

  task automatic count_lit(input int n, output int c0, output int c1);
    c0 = 0; c1 = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (dig0 !== '1) c0++;
      if (dig1 !== '1) c1++;
    end
  endtask

  typedef struct {
    logic [2:0]  a;
    logic [31:0] wd;
    logic [31:0] exp0;
    logic [31:0] exp1;
  } vec_t;

  vec_t tbl [11];

  initial begin
    logic [31:0] r0, r1, s1v, s2v;
    logic [31:0] ctrl_all;
    int c0, c1, n, last, armed;
    int seqv [$];
    int exps [6] = '{0, 1, 2, 3, 4, 0};

    ctrl_all = BLINK_ON ? 32'h11F : 32'h01F;
    tbl[0]  = '{3'd0, 32'h76543210, 32'h76543210, 32'h00043210};
    tbl[1]  = '{3'd1, 32'hFFFFFFFF, 32'h0,        32'h0};
    tbl[2]  = '{3'd2, 32'hFFFFFFFF, 32'hFF,       32'h1F};
    tbl[3]  = '{3'd3, 32'h000000A5, 32'hA5,       32'h05};
    tbl[4]  = '{3'd4, 32'hFFFFFFFF, ctrl_all,     ctrl_all};
    tbl[5]  = '{3'd4, 32'h00000013, 32'h13,       32'h13};
    tbl[6]  = '{3'd6, 32'hDEADBEEF, 32'h0,        32'h0};
    tbl[7]  = '{3'd7, 32'h12345678, 32'h0,        32'h0};
    tbl[8]  = '{3'd3, 32'h00000000, 32'h0,        32'h0};
    tbl[9]  = '{3'd2, 32'h00000001, 32'h1,        32'h1};
    tbl[10] = '{3'd4, 32'h0000001F, 32'h1F,       32'h1F};

    // Reset held three cycles.
    HRESETn = 1'b0;
    repeat (3) step();
    check32("rst_digit0", 32'(dig0), 32'hFF);
    check32("rst_seg0",   32'(seg0), 32'hFF);
    check32("rst_digit1", 32'(dig1), 32'h1F);
    HRESETn = 1'b1;
    rd(3'd4, r0, r1);
    check32("rst_ctrl0", r0, 32'h1F);
    check32("rst_ctrl1", r1, 32'h1F);
    rd(3'd0, r0, r1);
    check32("rst_data_lo", r0, 32'h0);

    foreach (tbl[i]) begin
      wr(tbl[i].a, tbl[i].wd);
      rd(tbl[i].a, r0, r1);
      check32($sformatf("tbl%0d_dut0", i), r0, tbl[i].exp0);
      check32($sformatf("tbl%0d_dut1", i), r1, tbl[i].exp1);
    end

    // Hex display on the 8-digit instance.
    n = 0; while (dig0 !== 8'hFE && n < 300) begin step(); n++; end
    check32("hex_d0_digit", 32'(dig0), 32'hFE);
    check32("hex_d0_seg",   32'(seg0), 32'h80);
    n = 0; while (dig0 !== 8'hFD && n < 300) begin step(); n++; end
    check32("hex_d1_digit", 32'(dig0), 32'hFD);
    check32("hex_d1_seg",   32'(seg0), 32'hF3);
    n = 0; while (dig0 !== 8'h7F && n < 300) begin step(); n++; end
    check32("hex_d7_seg",   32'(seg0), 32'hF1);
    n = 0; while (dig0 === 8'h7F && n < 300) begin step(); n++; end
    check32("hex_wrap", 32'(dig0), 32'hFE);

    // Scan index sequence on the 5-digit instance.
    armed = 0; last = -1;
    for (int k = 0; k < 1000 && seqv.size() < 6; k++) begin
      rd(3'd5, r0, r1);
      if (armed == 1 && int'(r1[3:0]) != last) seqv.push_back(int'(r1[3:0]));
      if (r1[3:0] == 4'd4) armed = 1;
      last = int'(r1[3:0]);
    end
    check32("odd_seq_len", 32'(seqv.size()), 32'd6);
    for (int k = 0; k < 6 && k < seqv.size(); k++)
      check32($sformatf("odd_seq%0d", k), 32'(seqv[k]), 32'(exps[k]));

    // Blanking digit 2.
    wr(3'd3, 32'h4);
    step();
    c0 = 0; c1 = 0;
    for (int i = 0; i < 128; i++) begin
      step();
      if (dig0 === 8'hFB) c0++;
      if (dig0 !== 8'hFF) c1++;
    end
    check32("blank_d2", 32'(c0), 32'd0);
    check32("blank_others", 32'(c1), 32'd112);

    // ENABLE=0 darkens from the next cycle while scanning continues.
    wr(3'd4, 32'h00F);
    count_lit(64, c0, c1);
    check32("disable_dark", 32'(c0 + c1), 32'd0);
    rd(3'd5, s1v, r1);
    repeat (20) step();
    rd(3'd5, s2v, r1);
    check32("status_adv", {31'h0, s1v != s2v}, 32'h1);

    // Brightness PWM.
    wr(3'd3, 32'h0);
    wr(3'd4, 32'h013);
    step();
    count_lit(640, c0, c1);
    check32("bright3_d0", 32'(c0), 32'd160);
    check32("bright3_d1", 32'(c1), 32'd160);
    wr(3'd4, 32'h010);
    step();
    count_lit(640, c0, c1);
    check32("bright0_d0", 32'(c0), 32'd40);
    check32("bright0_d1", 32'(c1), 32'd40);

    // Blink: half of each 128-cycle blink period is dark when compiled in.
    wr(3'd4, 32'h11F);
    rd(3'd4, r0, r1);
    check32("blink_ctrl", r1, ctrl_all);
    step();
    count_lit(640, c0, c1);
    check32("blink_lit_d1", 32'(c1), BLINK_ON ? 32'd320 : 32'd640);
    check32("blink_lit_d0", 32'(c0), BLINK_ON ? 32'd320 : 32'd640);

    // Randomized bus traffic against the model.
    for (int k = 0; k < 200; k++) begin
      xfer(($urandom % 4) != 0, 2'($urandom), ($urandom % 2) == 1, $urandom, $urandom, r0, r1);
      repeat ($urandom_range(0, 12)) step();
    end

    // Reset in the middle of a scan.
    wr(3'd0, 32'h89ABCDEF);
    repeat ($urandom_range(1, 40)) step();
    HRESETn = 1'b0;
    step();
    check32("midrst_digit0", 32'(dig0), 32'hFF);
    check32("midrst_seg1",   32'(seg1), 32'hFF);
    HRESETn = 1'b1;
    rd(3'd0, r0, r1);
    check32("midrst_data", r0, 32'h0);
    rd(3'd4, r0, r1);
    check32("midrst_ctrl", r1, 32'h1F);
    rd(3'd5, r0, r1);
    check32("midrst_status", r0 & 32'hFFFFFFF0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
